// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory pipeline stage.
package mem_stage_pkg;

  typedef enum logic {IDLE, WAIT} mem_state_t;

  localparam int DEFAULT_TIMEOUT = 16;

  // Low address bits that must be zero for a word access to be aligned.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/mem_stage_if.sv
// Data memory request/acknowledge bus. The memory stage is the master,
// the data memory is the slave.
interface mem_stage_if #(
  parameter int WIDTH = 32
);

  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/mem_stage_flop_wb.sv
// MEM/WB pipeline register. When enabled it either captures the completed
// instruction or, if bubble_i is set, loads an all-zero bubble.
module flop_wb #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             bubble_i,
  input  logic             pcSrc_i,
  input  logic             regWrite_i,
  input  logic             memtoReg_i,
  input  logic [3:0]       wa3_i,
  input  logic [WIDTH-1:0] readData_i,
  input  logic [WIDTH-1:0] aluOut_i,
  output logic             pcSrc_o,
  output logic             regWrite_o,
  output logic             memtoReg_o,
  output logic [3:0]       wa3_o,
  output logic [WIDTH-1:0] readData_o,
  output logic [WIDTH-1:0] aluOut_o
);

  localparam int REG_W = 2 * WIDTH + 7;

  logic [REG_W-1:0] wb_d;
  logic [REG_W-1:0] wb_q;

  assign wb_d = {pcSrc_i, regWrite_i, memtoReg_i, wa3_i, readData_i, aluOut_i};

  // Capture the instruction, or a bubble while the stage is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_q <= '0;
    end else if (en_i) begin
      wb_q <= bubble_i ? '0 : wb_d;
    end
  end

  assign {pcSrc_o, regWrite_o, memtoReg_o, wa3_o, readData_o, aluOut_o} = wb_q;

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues loads/stores over a req/ack bus, stalls the
// upstream pipeline while an access is outstanding, abandons accesses that
// time out, flags misaligned accesses and feeds the MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCSrcM,
  input  logic             RegWriteM,
  input  logic             MemWriteM,
  input  logic             MemtoRegM,
  input  logic [3:0]       WA3M,
  input  logic [WIDTH-1:0] ALUResultM,
  input  logic [WIDTH-1:0] WriteDataM,
  mem_stage_if.master      mem,
  output logic             StallM,
  output logic             MemErr,
  output logic             PCSrcW,
  output logic             RegWriteW,
  output logic             MemtoRegW,
  output logic [3:0]       WA3W,
  output logic [WIDTH-1:0] ReadDataW,
  output logic [WIDTH-1:0] ALUOutW
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mem_state_t       state_q;
  logic [CNT_W-1:0] waitCnt_q;
  logic             memErr_q;

  logic             memOp;
  logic             misaligned;
  logic             inWait;
  logic             reqInt;
  logic             ackSeen;
  logic             timeoutHit;
  logic             stall;
  logic             errComplete;
  logic             pcSrcD;
  logic             regWriteD;
  logic [WIDTH-1:0] readDataD;

  // Decode the M-stage instruction and the handshake condition for this cycle.
  always_comb begin
    memOp       = MemtoRegM | MemWriteM;
    misaligned  = memOp & ((ALUResultM[1:0] & ALIGN_MASK) != 2'b00);
    inWait      = (state_q == WAIT);
    reqInt      = ~reset & (inWait | (memOp & ~misaligned));
    ackSeen     = reqInt & mem.mem_ack;
    timeoutHit  = ~reset & inWait & ~mem.mem_ack & (waitCnt_q == CNT_LAST);
    stall       = reqInt & ~mem.mem_ack & ~timeoutHit;
    errComplete = ~reset & ((~inWait & misaligned) | timeoutHit);
    pcSrcD      = PCSrcM & ~errComplete;
    regWriteD   = RegWriteM & ~errComplete;
    readDataD   = ackSeen ? mem.mem_rdata : '0;
  end

  assign mem.mem_req   = reqInt;
  assign mem.mem_we    = ~reset & MemWriteM & ~MemtoRegM;
  assign mem.mem_addr  = reset ? '0 : ALUResultM;
  assign mem.mem_wdata = reset ? '0 : WriteDataM;
  assign StallM        = stall;
  assign MemErr        = memErr_q;

  // Access FSM with its wait counter and the sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      waitCnt_q <= '0;
      memErr_q  <= 1'b0;
    end else begin
      if (errComplete) begin
        memErr_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (stall) begin
            state_q   <= WAIT;
            waitCnt_q <= '0;
          end
        end
        WAIT: begin
          if (ackSeen || timeoutHit) begin
            state_q <= IDLE;
          end else begin
            waitCnt_q <= waitCnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  flop_wb #(
    .WIDTH(WIDTH)
  ) uWb (
    .clk        (clk),
    .reset      (reset),
    .en_i       (1'b1),
    .bubble_i   (stall),
    .pcSrc_i    (pcSrcD),
    .regWrite_i (regWriteD),
    .memtoReg_i (MemtoRegM),
    .wa3_i      (WA3M),
    .readData_i (readDataD),
    .aluOut_i   (ALUResultM),
    .pcSrc_o    (PCSrcW),
    .regWrite_o (RegWriteW),
    .memtoReg_o (MemtoRegW),
    .wa3_o      (WA3W),
    .readData_o (ReadDataW),
    .aluOut_o   (ALUOutW)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: ALU pass-through, loads and stores with
// immediate and delayed ack, misaligned access, timeout and reset in WAIT.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        PCSrcM, RegWriteM, MemWriteM, MemtoRegM;
  logic [3:0]  WA3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic        StallM, MemErr;
  logic        PCSrcW, RegWriteW, MemtoRegW;
  logic [3:0]  WA3W;
  logic [31:0] ReadDataW, ALUOutW;

  int checkCount = 0;
  int failCount  = 0;
  int stallCount;

  mem_stage_if #(.WIDTH(32)) memBus ();

  mem_stage #(
    .WIDTH   (32),
    .TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .PCSrcM     (PCSrcM),
    .RegWriteM  (RegWriteM),
    .MemWriteM  (MemWriteM),
    .MemtoRegM  (MemtoRegM),
    .WA3M       (WA3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .mem        (memBus),
    .StallM     (StallM),
    .MemErr     (MemErr),
    .PCSrcW     (PCSrcW),
    .RegWriteW  (RegWriteW),
    .MemtoRegW  (MemtoRegW),
    .WA3W       (WA3W),
    .ReadDataW  (ReadDataW),
    .ALUOutW    (ALUOutW)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic pcSrc, input logic regWrite, input logic memWrite,
                               input logic memtoReg, input logic [3:0] wa3,
                               input logic [31:0] alu, input logic [31:0] wdata);
    PCSrcM     = pcSrc;
    RegWriteM  = regWrite;
    MemWriteM  = memWrite;
    MemtoRegM  = memtoReg;
    WA3M       = wa3;
    ALUResultM = alu;
    WriteDataM = wdata;
  endtask

  task automatic setMem(input logic ack, input logic [31:0] rdata);
    memBus.mem_ack   = ack;
    memBus.mem_rdata = rdata;
  endtask

  // Directed sequence.
  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 32'h0000_0010, 32'h0);
    setMem(1'b0, 32'h0);
    #1;
    checkOutput("req forced low in reset", memBus.mem_req, 32'd0);
    checkOutput("stall forced low in reset", StallM, 32'd0);
    tick();
    tick();
    checkOutput("reset RegWriteW", RegWriteW, 32'd0);
    checkOutput("reset WA3W", WA3W, 32'd0);
    checkOutput("reset ALUOutW", ALUOutW, 32'd0);
    checkOutput("reset MemErr", MemErr, 32'd0);
    reset = 1'b0;

    // ALU op passes straight through.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 32'h0000_1234, 32'h0);
    #1;
    checkOutput("alu no stall", StallM, 32'd0);
    checkOutput("alu no req", memBus.mem_req, 32'd0);
    tick();
    checkOutput("alu RegWriteW", RegWriteW, 32'd1);
    checkOutput("alu WA3W", WA3W, 32'd5);
    checkOutput("alu ALUOutW", ALUOutW, 32'h0000_1234);
    checkOutput("alu MemtoRegW", MemtoRegW, 32'd0);

    // Load acked in the same cycle.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd7, 32'h0000_0100, 32'h0);
    setMem(1'b1, 32'hDEAD_BEEF);
    #1;
    checkOutput("load0 req", memBus.mem_req, 32'd1);
    checkOutput("load0 we", memBus.mem_we, 32'd0);
    checkOutput("load0 no stall", StallM, 32'd0);
    tick();
    setMem(1'b0, 32'h0);
    checkOutput("load0 ReadDataW", ReadDataW, 32'hDEAD_BEEF);
    checkOutput("load0 MemtoRegW", MemtoRegW, 32'd1);
    checkOutput("load0 RegWriteW", RegWriteW, 32'd1);
    checkOutput("load0 WA3W", WA3W, 32'd7);

    // Store acked after three stalled cycles.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 32'h0000_0040, 32'hCAFE_F00D);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("store stall", StallM, 32'd1);
      checkOutput("store req", memBus.mem_req, 32'd1);
      checkOutput("store we", memBus.mem_we, 32'd1);
      checkOutput("store addr stable", memBus.mem_addr, 32'h0000_0040);
      checkOutput("store wdata stable", memBus.mem_wdata, 32'hCAFE_F00D);
      tick();
      checkOutput("store bubble WA3W", WA3W, 32'd0);
      checkOutput("store bubble ALUOutW", ALUOutW, 32'd0);
    end
    setMem(1'b1, 32'h0);
    #1;
    checkOutput("store ack no stall", StallM, 32'd0);
    tick();
    setMem(1'b0, 32'h0);
    checkOutput("store done WA3W", WA3W, 32'd3);
    checkOutput("store done ALUOutW", ALUOutW, 32'h0000_0040);
    checkOutput("store MemErr", MemErr, 32'd0);

    // Reset arriving in the second WAIT cycle.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd9, 32'h0000_0200, 32'h0);
    tick();
    tick();
    #1;
    checkOutput("wait2 req before reset", memBus.mem_req, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("reset drops req", memBus.mem_req, 32'd0);
    checkOutput("reset drops stall", StallM, 32'd0);
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
    #1;
    checkOutput("after reset idle req", memBus.mem_req, 32'd0);
    checkOutput("after reset RegWriteW", RegWriteW, 32'd0);
    checkOutput("after reset MemtoRegW", MemtoRegW, 32'd0);
    checkOutput("after reset WA3W", WA3W, 32'd0);
    checkOutput("after reset ALUOutW", ALUOutW, 32'd0);
    tick();

    // Misaligned load: no request, sticky error, no register write.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd4, 32'h0000_0102, 32'h0);
    #1;
    checkOutput("misaligned no req", memBus.mem_req, 32'd0);
    checkOutput("misaligned no stall", StallM, 32'd0);
    checkOutput("misaligned MemErr not yet", MemErr, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
    checkOutput("misaligned MemErr", MemErr, 32'd1);
    checkOutput("misaligned RegWriteW", RegWriteW, 32'd0);
    checkOutput("misaligned PCSrcW", PCSrcW, 32'd0);
    repeat (3) tick();
    checkOutput("MemErr sticky", MemErr, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("MemErr cleared by reset", MemErr, 32'd0);

    // Load that is never acked: abandoned after the timeout.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 32'h0000_0300, 32'h0);
    stallCount = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!StallM) break;
      stallCount++;
      @(posedge clk);
      #1;
    end
    checkOutput("timeout stall cycles", stallCount, 32'd16);
    checkOutput("timeout MemErr not yet", MemErr, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
    checkOutput("timeout MemErr", MemErr, 32'd1);
    checkOutput("timeout ReadDataW", ReadDataW, 32'd0);
    checkOutput("timeout RegWriteW", RegWriteW, 32'd0);
    setMem(1'b1, 32'h5555_5555);
    #1;
    checkOutput("late ack no req", memBus.mem_req, 32'd0);
    checkOutput("late ack no stall", StallM, 32'd0);
    tick();
    setMem(1'b0, 32'h0);
    checkOutput("late ack ReadDataW", ReadDataW, 32'd0);
    checkOutput("late ack MemErr", MemErr, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
